// File: rtl/fifo_param.sv
// Single-clock synchronous FIFO with registered read data, occupancy count,
// almost-full/almost-empty thresholds and one-cycle overflow/underflow pulses.
module fifo_param #(
  parameter int DATA_WIDTH   = 8,
  parameter int ADDR_WIDTH   = 5,
  parameter int AFULL_LEVEL  = 28,
  parameter int AEMPTY_LEVEL = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  write,
  input  logic [DATA_WIDTH-1:0] datain,
  input  logic                  read,
  output logic [DATA_WIDTH-1:0] dataout,
  output logic                  dataValid,
  output logic                  full,
  output logic                  empty,
  output logic                  almostFull,
  output logic                  almostEmpty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int PW    = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] AFULL_CNT  = PW'(AFULL_LEVEL);
  localparam logic [PW-1:0] AEMPTY_CNT = PW'(AEMPTY_LEVEL);
  localparam logic [PW-1:0] PTR_ONE    = PW'(1);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [DATA_WIDTH-1:0] dataout_q;
  logic                  valid_q, valid_d;
  logic                  ovf_q, ovf_d;
  logic                  udf_q, udf_d;

  logic                  read_en;
  logic                  write_en;
  logic [PW-1:0]         count_w;

  // Pointers carry an extra wrap bit so full and empty are distinguishable
  // when the low address bits match.
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]) &&
                   (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]);
  assign count_w = wr_ptr_q - rd_ptr_q;

  assign count       = count_w;
  assign almostFull  = (count_w >= AFULL_CNT);
  assign almostEmpty = (count_w <= AEMPTY_CNT);

  // No fall-through: an empty FIFO never serves a read, even with a write
  // in the same cycle. A full FIFO can take a write if a read frees a slot.
  assign read_en  = read & ~empty & ~flush;
  assign write_en = write & (~full | read_en) & ~flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    valid_d  = 1'b0;
    ovf_d    = 1'b0;
    udf_d    = 1'b0;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (write_en) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (read_en)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      valid_d = read_en;
      ovf_d   = write & ~write_en;
      udf_d   = read & ~read_en;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      dataout_q <= '0;
      valid_q   <= 1'b0;
      ovf_q     <= 1'b0;
      udf_q     <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      valid_q  <= valid_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
      if (read_en) dataout_q <= mem_q[rd_ptr_q[ADDR_WIDTH-1:0]];
    end
  end

  // Storage is deliberately not reset; the pointers define what is valid.
  always_ff @(posedge clock) begin
    if (write_en) mem_q[wr_ptr_q[ADDR_WIDTH-1:0]] <= datain;
  end

  assign dataout   = dataout_q;
  assign dataValid = valid_q;
  assign overflow  = ovf_q;
  assign underflow = udf_q;

endmodule

// File: tb/tb_fifo_param.sv
// Directed bench for fifo_param: each cycle is checked against a queue
// reference plus explicit hand-computed values at the interesting points.
module tb_fifo_param;

  logic       clock = 1'b0;
  logic       reset;
  logic       flush;
  logic       write;
  logic [7:0] datain;
  logic       read;
  logic [7:0] dataout;
  logic       dataValid, full, empty, almostFull, almostEmpty;
  logic [5:0] count;
  logic       overflow, underflow;

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0] q[$];
  logic [7:0] last_out;

  fifo_param #(
    .DATA_WIDTH(8), .ADDR_WIDTH(5), .AFULL_LEVEL(28), .AEMPTY_LEVEL(4)
  ) dut (
    .clock(clock), .reset(reset), .flush(flush), .write(write),
    .datain(datain), .read(read), .dataout(dataout), .dataValid(dataValid),
    .full(full), .empty(empty), .almostFull(almostFull),
    .almostEmpty(almostEmpty), .count(count), .overflow(overflow),
    .underflow(underflow)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_state(input logic exp_valid, input logic exp_ovf, input logic exp_udf);
    int n;
    n = q.size();
    chk("dataValid", dataValid, exp_valid);
    chk("dataout", dataout, last_out);
    chk("overflow", overflow, exp_ovf);
    chk("underflow", underflow, exp_udf);
    chk("count", count, n);
    chk("full", full, n == 32);
    chk("empty", empty, n == 0);
    chk("almostFull", almostFull, n >= 28);
    chk("almostEmpty", almostEmpty, n <= 4);
  endtask

  // One clock with the given request; reference updated from the bench's
  // own view of occupancy, then all outputs are compared.
  task automatic cycle(input logic wr, input logic rd, input logic fl, input logic [7:0] din);
    logic rd_ok, wr_ok, ovf, udf;
    write = wr; read = rd; flush = fl; datain = din;
    @(posedge clock);
    #1;
    rd_ok = 1'b0; wr_ok = 1'b0; ovf = 1'b0; udf = 1'b0;
    if (fl) begin
      q.delete();
    end else begin
      rd_ok = rd && (q.size() != 0);
      wr_ok = wr && ((q.size() < 32) || rd_ok);
      if (rd_ok) last_out = q.pop_front();
      if (wr_ok) q.push_back(din);
      ovf = wr && !wr_ok;
      udf = rd && !rd_ok;
    end
    write = 1'b0; read = 1'b0; flush = 1'b0;
    check_state(rd_ok, ovf, udf);
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; write = 1'b0; read = 1'b0; datain = 8'h00;
    last_out = 8'h00;
    #2;
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_aempty", almostEmpty, 1);
    chk("rst_full", full, 0);
    chk("rst_afull", almostFull, 0);
    chk("rst_dataout", dataout, 0);
    chk("rst_valid", dataValid, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_udf", underflow, 0);
    @(posedge clock); #1;
    reset = 1'b0;

    // Fill 0x01..0x20; thresholds checked by check_state at every count.
    for (int i = 1; i <= 32; i++) begin
      cycle(1'b1, 1'b0, 1'b0, 8'(i));
      if (i == 27) chk("afull_27", almostFull, 0);
      if (i == 28) chk("afull_28", almostFull, 1);
    end
    chk("fill_full", full, 1);
    chk("fill_count", count, 32);

    // Write to a full FIFO is rejected with a single overflow pulse.
    cycle(1'b1, 1'b0, 1'b0, 8'hAA);
    chk("ovf_pulse", overflow, 1);
    chk("ovf_count", count, 32);
    cycle(1'b0, 1'b0, 1'b0, 8'h00);
    chk("ovf_clear", overflow, 0);

    for (int i = 1; i <= 32; i++) begin
      cycle(1'b0, 1'b1, 1'b0, 8'h00);
      chk("drain_data", dataout, i);
    end
    cycle(1'b0, 1'b0, 1'b0, 8'h00);
    chk("hold_data", dataout, 8'h20);
    chk("hold_valid", dataValid, 0);

    // Read on empty is rejected.
    cycle(1'b0, 1'b1, 1'b0, 8'h00);
    chk("udf_pulse", underflow, 1);

    // Empty with simultaneous read+write: write only, underflow pulses.
    cycle(1'b1, 1'b1, 1'b0, 8'h77);
    chk("ew_udf", underflow, 1);
    chk("ew_valid", dataValid, 0);
    chk("ew_count", count, 1);
    cycle(1'b0, 1'b1, 1'b0, 8'h00);
    chk("ew_data", dataout, 8'h77);

    // Full with simultaneous read+write: both accepted.
    for (int i = 1; i <= 32; i++) cycle(1'b1, 1'b0, 1'b0, 8'(i));
    cycle(1'b1, 1'b1, 1'b0, 8'h55);
    chk("fw_count", count, 32);
    chk("fw_data", dataout, 8'h01);
    chk("fw_ovf", overflow, 0);
    for (int i = 2; i <= 32; i++) cycle(1'b0, 1'b1, 1'b0, 8'h00);
    chk("fw_last", dataout, 8'h20);
    cycle(1'b0, 1'b1, 1'b0, 8'h00);
    chk("fw_55", dataout, 8'h55);
    chk("fw_empty", empty, 1);

    // 100 write/read pairs with random gaps; pointers wrap several times.
    for (int i = 0; i < 100; i++) begin
      cycle(1'b1, 1'b0, 1'b0, 8'(8'h80 + i));
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) cycle(1'b0, 1'b0, 1'b0, 8'h00);
      cycle(1'b0, 1'b1, 1'b0, 8'h00);
      chk("wrap_data", dataout, 8'(8'h80 + i));
    end

    // Flush after 10 entries, with read and write also requested.
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 1'b0, 8'(8'h40 + i));
    cycle(1'b1, 1'b1, 1'b1, 8'hEE);
    chk("flush_count", count, 0);
    chk("flush_empty", empty, 1);
    chk("flush_valid", dataValid, 0);
    cycle(1'b1, 1'b0, 1'b0, 8'h3C);
    cycle(1'b0, 1'b1, 1'b0, 8'h00);
    chk("flush_next", dataout, 8'h3C);

    // Asynchronous reset in the middle of a burst.
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 1'b0, 8'(8'h60 + i));
    cycle(1'b1, 1'b1, 1'b0, 8'h66);
    write = 1'b1; read = 1'b1; datain = 8'h67;
    #2;
    reset = 1'b1;
    #1;
    chk("arst_count", count, 0);
    chk("arst_empty", empty, 1);
    chk("arst_dataout", dataout, 0);
    chk("arst_valid", dataValid, 0);
    chk("arst_aempty", almostEmpty, 1);
    q.delete();
    last_out = 8'h00;
    @(posedge clock); #1;
    write = 1'b0; read = 1'b0;
    reset = 1'b0;
    check_state(1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 8'h99);
    cycle(1'b0, 1'b1, 1'b0, 8'h00);
    chk("arst_first", dataout, 8'h99);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_param.md
FIFO_PARAM -- requirements
Module: fifo_param

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, width of datain/dataout in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 5, log2 of storage depth; DEPTH = 2**ADDR_WIDTH (32 by default).
REQ-003 SHALL have parameter AFULL_LEVEL, default 28, count at or above which almostFull asserts.
REQ-004 SHALL have parameter AEMPTY_LEVEL, default 4, count at or below which almostEmpty asserts.
REQ-005 SHALL have port clock, input, 1, single clock; all state updates on rising edge.
REQ-006 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port flush, input, 1, synchronous clear of contents.
REQ-008 SHALL have port write, input, 1, write request.
REQ-009 SHALL have port datain, input, DATA_WIDTH, write data.
REQ-010 SHALL have port read, input, 1, read request.
REQ-011 SHALL have port dataout, output, DATA_WIDTH, registered read data.
REQ-012 SHALL have port dataValid, output, 1, dataout updated by an accepted read this cycle.
REQ-013 SHALL have port full, output, 1, count == DEPTH.
REQ-014 SHALL have port empty, output, 1, count == 0.
REQ-015 SHALL have port almostFull, output, 1, count >= AFULL_LEVEL.
REQ-016 SHALL have port almostEmpty, output, 1, count <= AEMPTY_LEVEL.
REQ-017 SHALL have port count, output, ADDR_WIDTH+1, current occupancy, 0..DEPTH.
REQ-018 SHALL have port overflow, output, 1, one-cycle pulse on a rejected write.
REQ-019 SHALL have port underflow, output, 1, one-cycle pulse on a rejected read.

Function
REQ-020 SHALL keep write and read pointers of ADDR_WIDTH+1 bits; the low ADDR_WIDTH bits address storage; the MSB is the wrap bit.
REQ-021 SHALL derive full as: MSBs differ and low bits equal. SHALL derive empty as: pointers equal.
REQ-022 SHALL compute count as writePtr - readPtr modulo 2**(ADDR_WIDTH+1).
REQ-023 SHALL derive full, empty, almostFull, almostEmpty and count combinationally from the registered pointers, with no extra latency.
REQ-024 SHALL accept a read (readEn) when read=1 and empty=0.
REQ-025 SHALL accept a write (writeEn) when write=1 and either full=0, or full=1 and a read is accepted in the same cycle.
REQ-026 SHALL, on an accepted write, store datain at writePtr[ADDR_WIDTH-1:0] and increment writePtr by 1 with natural wrap.
REQ-027 SHALL, on an accepted read, load dataout with storage[readPtr] on the same edge, set dataValid=1 for that cycle, and increment readPtr by 1. Read latency is one clock.
REQ-028 SHALL hold dataout at its last value when no read is accepted, and drive dataValid=0.
REQ-029 SHALL, when empty and read and write are both asserted, reject the read (no fall-through), accept the write, and pulse underflow.
REQ-030 SHALL pulse overflow for one cycle when write=1 is rejected, and pulse underflow for one cycle when read=1 is rejected; neither flag is sticky.
REQ-031 SHALL, on flush=1, set both pointers to 0 and drive dataValid, overflow and underflow to 0. Flush overrides read and write in the same cycle. Storage contents and dataout are unchanged.
REQ-032 SHALL leave count unchanged when one write and one read are accepted in the same cycle.
REQ-033 SHALL require 0 < AEMPTY_LEVEL < AFULL_LEVEL < DEPTH; behaviour outside this range is unspecified.

Reset
REQ-034 SHALL, while reset=1 and regardless of clock, set writePtr=0, readPtr=0, dataout=0, dataValid=0, overflow=0 and underflow=0. Resulting outputs: empty=1, almostEmpty=1, full=0, almostFull=0, count=0.
REQ-035 SHALL give reset priority over flush, read and write. Storage array contents need not be reset.
REQ-036 SHALL discard all in-flight data when reset asserts mid-operation; the first accepted write after reset lands at address 0.

Verification
REQ-037 Reset, then write 0x01..0x20 on 32 consecutive cycles -> full=1 and count=32 after the last write; almostFull first asserts when count reaches 28.
REQ-038 When full, assert write only with datain 0xAA -> overflow pulses for one cycle; count stays 32; subsequent reads return 0x01..0x20 in order with dataValid=1 and 1-cycle latency.
REQ-039 When full, assert read and write (datain 0x55) in the same cycle -> both accepted, count stays 32, dataout=0x01; 0x55 is read back 32 reads later.
REQ-040 When empty, assert read and write (datain 0x77) in the same cycle -> underflow pulses, dataValid=0, count=1; the next read returns 0x77.
REQ-041 Run 100 write/read pairs with random gaps -> pointers wrap past 63; data stays in order; count never exceeds 32 or underflows.
REQ-042 Fill 10 entries, then assert flush -> count=0 and empty=1 on the next cycle; separately, assert reset asynchronously mid-burst -> outputs reach reset values before the next clock edge.
